cn2_input_conditioner: RTL and testbench

//  Conditions N_CH raw active-low operator switches (coins, starts, joysticks, punch, test) into clean

---
 rtl/cn2_input_conditioner.sv | 153 +++++++++++++++
 tb/tb_cn2_input_conditioner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cn2_input_conditioner.sv
// Conditions raw active-low operator switches into clean CN2 levels: 2-flop sync, debounce, press strobe,
// coin pulse stretch with one credit per press, saturating shared coin counter and per-pin force override.
module cn2_input_conditioner #(
   parameter int                N_CH              = 23,
   parameter int                DEBOUNCE_CYCLES   = 100000,
   parameter logic [N_CH-1:0]   COIN_MASK         = 'b11,
   parameter int                COIN_PULSE_CYCLES = 500000,
   parameter int                CNT_W             = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_CH-1:0]   sw_n_i,
   input  logic [N_CH-1:0]   force_en_i,
   input  logic [N_CH-1:0]   force_val_i,
   input  logic              coin_cnt_clr_i,
   output logic [N_CH-1:0]   cn2_out_o,
   output logic [N_CH-1:0]   press_stb_o,
   output logic              coin_evt_o,
   output logic [CNT_W-1:0]  coin_cnt_o
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_W = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
   localparam int SUM_W = CNT_W + $clog2(N_CH + 1) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_WAIT_REL
   } coin_st_t;

   logic [N_CH-1:0]  s1_q, s2_q;
   logic [N_CH-1:0]  db_q, db_d;
   logic [DB_W-1:0]  cnt_q [N_CH];
   logic [DB_W-1:0]  cnt_d [N_CH];
   coin_st_t         st_q  [N_CH];
   coin_st_t         st_d  [N_CH];
   logic [TMR_W-1:0] tmr_q [N_CH];
   logic [TMR_W-1:0] tmr_d [N_CH];
   logic [N_CH-1:0]  fall;
   logic [N_CH-1:0]  credit;
   logic [N_CH-1:0]  cond;
   logic [N_CH-1:0]  press_stb_q, press_stb_d;
   logic             coin_evt_q, coin_evt_d;
   logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
   logic [SUM_W-1:0] credit_sum, cnt_base, cnt_sum;

   // A level is accepted only after the synchronised input disagrees with it for DEBOUNCE_CYCLES edges.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign fall = db_q & ~db_d;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         st_d[i]        = st_q[i];
         tmr_d[i]       = tmr_q[i];
         credit[i]      = 1'b0;
         cond[i]        = db_q[i];
         press_stb_d[i] = fall[i];
         if (COIN_MASK[i]) begin
            press_stb_d[i] = 1'b0;
            case (st_q[i])
               ST_IDLE: begin
                  cond[i] = 1'b1;
                  if (fall[i]) begin
                     st_d[i]        = ST_PULSE;
                     tmr_d[i]       = '0;
                     credit[i]      = 1'b1;
                     press_stb_d[i] = 1'b1;
                  end
               end
               ST_PULSE: begin
                  cond[i]  = 1'b0;
                  tmr_d[i] = tmr_q[i] + TMR_W'(1);
                  if (tmr_q[i] == TMR_W'(COIN_PULSE_CYCLES - 1)) begin
                     st_d[i] = ST_WAIT_REL;
                  end
               end
               ST_WAIT_REL: begin
                  cond[i] = db_q[i];
                  if (db_q[i]) begin
                     st_d[i] = ST_IDLE;
                  end
               end
               default: begin
                  st_d[i] = ST_IDLE;
               end
            endcase
         end else begin
            st_d[i] = ST_IDLE;
         end
      end
   end

   // Several coin channels may credit on the same edge; a clear restarts the count from those credits.
   always_comb begin
      credit_sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         credit_sum = credit_sum + SUM_W'(credit[i]);
      end
      cnt_base   = coin_cnt_clr_i ? '0 : {{(SUM_W-CNT_W){1'b0}}, coin_cnt_q};
      cnt_sum    = cnt_base + credit_sum;
      coin_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
      coin_evt_d = |credit;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q        <= '1;
         s2_q        <= '1;
         db_q        <= '1;
         press_stb_q <= '0;
         coin_evt_q  <= 1'b0;
         coin_cnt_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
            st_q[i]  <= ST_IDLE;
            tmr_q[i] <= '0;
         end
      end else begin
         s1_q        <= sw_n_i;
         s2_q        <= s1_q;
         db_q        <= db_d;
         press_stb_q <= press_stb_d;
         coin_evt_q  <= coin_evt_d;
         coin_cnt_q  <= coin_cnt_d;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            st_q[i]  <= st_d[i];
            tmr_q[i] <= tmr_d[i];
         end
      end
   end

   assign cn2_out_o   = (force_en_i & force_val_i) | (~force_en_i & cond);
   assign press_stb_o = press_stb_q;
   assign coin_evt_o  = coin_evt_q;
   assign coin_cnt_o  = coin_cnt_q;

endmodule

// File: tb/tb_cn2_input_conditioner.sv
// Bench for cn2_input_conditioner: directed scenarios plus random switch activity against a behavioural model.
module tb_cn2_input_conditioner;

   localparam int       DB   = 4;
   localparam int       CP   = 6;
   localparam bit [3:0] COIN = 4'b0011;

   logic       clk;
   logic       rst;
   logic [3:0] sw_n;
   logic [3:0] force_en;
   logic [3:0] force_val;
   logic       clr;
   logic [3:0] cn2_out;
   logic [3:0] press_stb;
   logic       coin_evt;
   logic [1:0] coin_cnt;

   int checks = 0;
   int errors = 0;

   cn2_input_conditioner #(
      .N_CH(4), .DEBOUNCE_CYCLES(DB), .COIN_MASK(4'b0011), .COIN_PULSE_CYCLES(CP), .CNT_W(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .sw_n_i(sw_n), .force_en_i(force_en), .force_val_i(force_val),
      .coin_cnt_clr_i(clr), .cn2_out_o(cn2_out), .press_stb_o(press_stb), .coin_evt_o(coin_evt),
      .coin_cnt_o(coin_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: synchronised sample = raw value two edges old; accepted level changes after DB
   // consecutive disagreeing samples; a coin press is honoured only when armed (idle and released),
   // then holds the pin low for CP cycles and re-arms once the accepted level has returned high.
   bit [3:0] m_s1, m_s2, m_lvl, m_stb, m_armed;
   int       m_run [4];
   int       m_left[4];
   bit       m_evt;
   int       m_cnt;

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_lvl = '1; m_stb = '0; m_armed = '1; m_evt = 0; m_cnt = 0;
      for (int ch = 0; ch < 4; ch++) begin
         m_run[ch]  = 0;
         m_left[ch] = 0;
      end
   endtask

   task automatic model_step();
      int       credits;
      bit [3:0] new_lvl;
      bit       fell;
      credits = 0;
      new_lvl = m_lvl;
      if (rst) begin
         model_reset();
         return;
      end
      for (int ch = 0; ch < 4; ch++) begin
         if (m_s2[ch] != m_lvl[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == DB) begin
               new_lvl[ch] = m_s2[ch];
               m_run[ch]   = 0;
            end
         end else begin
            m_run[ch] = 0;
         end
      end
      for (int ch = 0; ch < 4; ch++) begin
         fell      = m_lvl[ch] && !new_lvl[ch];
         m_stb[ch] = 1'b0;
         if (!COIN[ch]) begin
            m_stb[ch] = fell;
         end else if (m_armed[ch]) begin
            if (fell) begin
               m_stb[ch]   = 1'b1;
               credits++;
               m_armed[ch] = 1'b0;
               m_left[ch]  = CP;
            end
         end else if (m_left[ch] > 0) begin
            m_left[ch]--;
         end else if (m_lvl[ch]) begin
            m_armed[ch] = 1'b1;
         end
      end
      m_evt = (credits > 0);
      m_cnt = clr ? credits : m_cnt + credits;
      if (m_cnt > 3) m_cnt = 3;
      m_lvl = new_lvl;
      m_s2  = m_s1;
      m_s1  = sw_n;
   endtask

   function automatic logic [3:0] exp_cn2();
      logic [3:0] v;
      for (int ch = 0; ch < 4; ch++) begin
         if (!COIN[ch])            v[ch] = m_lvl[ch];
         else if (m_left[ch] > 0)  v[ch] = 1'b0;
         else if (m_armed[ch])     v[ch] = 1'b1;
         else                      v[ch] = m_lvl[ch];
         if (force_en[ch]) v[ch] = force_val[ch];
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1; sw_n = 4'hF; force_en = '0; force_val = '0; clr = 0;
      tick();
      tick();
      checks++; if (cn2_out !== 4'hF) begin errors++; $display("FAIL reset_cn2 got %b exp 1111", cn2_out); end
      checks++; if (press_stb !== 4'h0) begin errors++; $display("FAIL reset_stb got %b exp 0000", press_stb); end
      checks++; if (coin_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", coin_cnt); end
      checks++; if (coin_evt !== 1'b0) begin errors++; $display("FAIL reset_evt got %b exp 0", coin_evt); end
      rst = 0;
      tick();
   endtask

   task automatic test_debounce();
      sw_n[2] = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         checks++; if (cn2_out[2] !== (t >= 5 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL deb_level t=%0d got %b exp %b", t, cn2_out[2], (t >= 5 ? 1'b0 : 1'b1)); end
         checks++; if (press_stb[2] !== (t == 5)) begin errors++; $display("FAIL deb_stb t=%0d got %b exp %b", t, press_stb[2], (t == 5)); end
         checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL deb_model_cn2 t=%0d got %b exp %b", t, cn2_out, exp_cn2()); end
      end
      sw_n[2] = 1'b1;
      for (int t = 0; t < 8; t++) begin
         tick();
         checks++; if (press_stb !== 4'h0) begin errors++; $display("FAIL deb_release_stb t=%0d got %b exp 0000", t, press_stb); end
      end
      checks++; if (cn2_out[2] !== 1'b1) begin errors++; $display("FAIL deb_released got %b exp 1", cn2_out[2]); end
      for (int t = 0; t < 12; t++) begin
         sw_n[3] = (t < 3) ? 1'b0 : 1'b1;
         tick();
         checks++; if (cn2_out[3] !== 1'b1) begin errors++; $display("FAIL glitch_level t=%0d got %b exp 1", t, cn2_out[3]); end
         checks++; if (press_stb[3] !== 1'b0) begin errors++; $display("FAIL glitch_stb t=%0d got %b exp 0", t, press_stb[3]); end
      end
   endtask

   task automatic test_coin_stretch();
      int lows, evts;
      lows = 0; evts = 0;
      for (int t = 0; t < 26; t++) begin
         sw_n[0] = (t < 6) ? 1'b0 : 1'b1;
         tick();
         if (cn2_out[0] === 1'b0) lows++;
         if (coin_evt === 1'b1) evts++;
         checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL stretch_cn2 t=%0d got %b exp %b", t, cn2_out, exp_cn2()); end
         checks++; if (coin_evt !== m_evt) begin errors++; $display("FAIL stretch_evt t=%0d got %b exp %b", t, coin_evt, m_evt); end
      end
      checks++; if (lows != CP) begin errors++; $display("FAIL stretch_low_cycles got %0d exp %0d", lows, CP); end
      checks++; if (evts != 1) begin errors++; $display("FAIL stretch_evt_count got %0d exp 1", evts); end
      checks++; if (coin_cnt !== 2'd1) begin errors++; $display("FAIL stretch_cnt got %0d exp 1", coin_cnt); end
   endtask

   task automatic test_coin_hold();
      int lows, evts, falls;
      logic prev;
      lows = 0; evts = 0; falls = 0; prev = cn2_out[1];
      for (int t = 0; t < 60; t++) begin
         sw_n[1] = (t < 40 && t != 15 && t != 16) ? 1'b0 : 1'b1;
         tick();
         if (cn2_out[1] === 1'b0) lows++;
         if (prev === 1'b1 && cn2_out[1] === 1'b0) falls++;
         prev = cn2_out[1];
         if (coin_evt === 1'b1) evts++;
         checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL hold_cn2 t=%0d got %b exp %b", t, cn2_out, exp_cn2()); end
         checks++; if (press_stb !== m_stb) begin errors++; $display("FAIL hold_stb t=%0d got %b exp %b", t, press_stb, m_stb); end
      end
      checks++; if (evts != 1) begin errors++; $display("FAIL hold_credits got %0d exp 1", evts); end
      checks++; if (falls != 1) begin errors++; $display("FAIL hold_low_runs got %0d exp 1", falls); end
      checks++; if (lows != 40) begin errors++; $display("FAIL hold_low_cycles got %0d exp 40", lows); end
      checks++; if (coin_cnt !== 2'd2) begin errors++; $display("FAIL hold_cnt got %0d exp 2", coin_cnt); end
   endtask

   task automatic test_simul_sat();
      int evts;
      evts = 0;
      sw_n[1:0] = 2'b00;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (coin_evt === 1'b1) evts++;
         checks++; if (coin_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL simul_cnt t=%0d got %0d exp %0d", t, coin_cnt, m_cnt); end
      end
      checks++; if (evts != 1) begin errors++; $display("FAIL simul_evt_count got %0d exp 1", evts); end
      checks++; if (coin_cnt !== 2'd3) begin errors++; $display("FAIL simul_sat got %0d exp 3", coin_cnt); end
      sw_n[1:0] = 2'b11;
      repeat (20) tick();
      sw_n[0] = 1'b0;
      repeat (6) tick();
      checks++; if (coin_evt !== 1'b1) begin errors++; $display("FAIL sat_evt got %b exp 1", coin_evt); end
      checks++; if (coin_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", coin_cnt); end
      sw_n[0] = 1'b1;
      repeat (20) tick();
      sw_n[1] = 1'b0;
      repeat (5) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (coin_evt !== 1'b1) begin errors++; $display("FAIL clr_evt got %b exp 1", coin_evt); end
      checks++; if (coin_cnt !== 2'd1) begin errors++; $display("FAIL clr_credit got %0d exp 1", coin_cnt); end
      sw_n[1] = 1'b1;
      repeat (20) tick();
      checks++; if (coin_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL clr_model_cnt got %0d exp %0d", coin_cnt, m_cnt); end
   endtask

   task automatic test_force_reset();
      force_en = 4'h1; force_val = 4'h0;
      #1;
      checks++; if (cn2_out[0] !== 1'b0) begin errors++; $display("FAIL force_zero_lat got %b exp 0", cn2_out[0]); end
      checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL force_model got %b exp %b", cn2_out, exp_cn2()); end
      force_en = 4'h0;
      #1;
      checks++; if (cn2_out[0] !== 1'b1) begin errors++; $display("FAIL force_off got %b exp 1", cn2_out[0]); end
      sw_n[0] = 1'b0;
      repeat (7) tick();
      checks++; if (cn2_out[0] !== 1'b0) begin errors++; $display("FAIL pulse_before_rst got %b exp 0", cn2_out[0]); end
      rst = 1;
      repeat (2) tick();
      checks++; if (cn2_out[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pulse got %b exp 1", cn2_out[0]); end
      checks++; if (coin_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", coin_cnt); end
      rst = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         checks++; if (coin_evt !== (t == 5)) begin errors++; $display("FAIL rst_recredit t=%0d got %b exp %b", t, coin_evt, (t == 5)); end
         checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL rst_model_cn2 t=%0d got %b exp %b", t, cn2_out, exp_cn2()); end
      end
      checks++; if (coin_cnt !== 2'd1) begin errors++; $display("FAIL rst_new_cnt got %0d exp 1", coin_cnt); end
      sw_n[0] = 1'b1;
      repeat (20) tick();
   endtask

   task automatic test_random();
      int hold[4];
      for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
      for (int t = 0; t < 600; t++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (hold[ch] == 0) begin
               sw_n[ch] = 1'($urandom_range(0, 1));
               hold[ch] = $urandom_range(1, 14);
            end else begin
               hold[ch]--;
            end
         end
         force_en  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         force_val = 4'($urandom);
         clr       = ($urandom_range(0, 31) == 0);
         tick();
         checks++; if (cn2_out !== exp_cn2()) begin errors++; $display("FAIL rand_cn2 t=%0d got %b exp %b", t, cn2_out, exp_cn2()); end
         checks++; if (press_stb !== m_stb) begin errors++; $display("FAIL rand_stb t=%0d got %b exp %b", t, press_stb, m_stb); end
         checks++; if (coin_evt !== m_evt) begin errors++; $display("FAIL rand_evt t=%0d got %b exp %b", t, coin_evt, m_evt); end
         checks++; if (coin_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL rand_cnt t=%0d got %0d exp %0d", t, coin_cnt, m_cnt); end
      end
      force_en = '0; clr = 0; sw_n = 4'hF;
   endtask

   initial begin
      clk = 0; rst = 1; sw_n = 4'hF; force_en = '0; force_val = '0; clr = 0;
      model_reset();
      test_reset();
      test_debounce();
      test_coin_stretch();
      test_coin_hold();
      test_simul_sat();
      test_force_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
